// File: rtl/cachedir_ctrl.sv
// cachedir_ctrl: controller for the 512x29 dual-port cache directory RAM.
// Port A serves bridge lookup/fill/invalidate requests (one every two cycles).
// Port B serves single-cycle snoop invalidations.
// After reset the whole directory is swept to zero before any traffic is accepted.
module cachedir_ctrl #(
    parameter int unsigned PA_WIDTH    = 40,
    parameter int unsigned LINE_BITS   = 4,
    parameter int unsigned INDEX_WIDTH = 9,
    parameter int unsigned TAG_WIDTH   = PA_WIDTH - LINE_BITS - INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [PA_WIDTH-1:0]    req_addr,
    input  logic                   req_dirty,

    output logic                   rsp_valid,
    output logic                   rsp_hit,
    output logic                   rsp_dirty,
    output logic                   rsp_evict,
    output logic [TAG_WIDTH-1:0]   rsp_evict_tag,
    output logic                   rsp_evict_dirty,

    input  logic                   snp_valid,
    output logic                   snp_ready,
    input  logic [PA_WIDTH-1:0]    snp_addr,
    output logic                   snp_hit,

    output logic                   init_done,

    output logic                   dir_wren_a,
    output logic [INDEX_WIDTH-1:0] dir_address_a,
    output logic [TAG_WIDTH+1:0]   dir_data_a,
    input  logic [TAG_WIDTH+1:0]   dir_q_a,

    output logic                   dir_wren_b,
    output logic [INDEX_WIDTH-1:0] dir_address_b,
    output logic [TAG_WIDTH+1:0]   dir_data_b,
    input  logic [TAG_WIDTH+1:0]   dir_q_b
);

    localparam int unsigned ENTRY_W = TAG_WIDTH + 2;
    localparam int unsigned SWEEP_W = INDEX_WIDTH - 1;
    localparam int unsigned TAG_LSB = LINE_BITS + INDEX_WIDTH;
    localparam int unsigned VLD_BIT = TAG_WIDTH + 1;
    localparam int unsigned DRT_BIT = TAG_WIDTH;

    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SWEEP_W-1:0]     r_sweep;
    logic                   r_init_done;
    logic                   r_req_ready;

    logic [1:0]             r_op;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_dirty;

    logic                   r_rsp_valid;
    logic                   r_rsp_hit;
    logic                   r_rsp_dirty;
    logic                   r_rsp_evict;
    logic [TAG_WIDTH-1:0]   r_rsp_evict_tag;
    logic                   r_rsp_evict_dirty;
    logic                   r_snp_hit;

    logic [INDEX_WIDTH-1:0] w_req_idx;
    logic [TAG_WIDTH-1:0]   w_req_tag;
    logic [INDEX_WIDTH-1:0] w_snp_idx;
    logic [TAG_WIDTH-1:0]   w_snp_tag;

    logic                   w_qa_valid;
    logic                   w_qa_dirty;
    logic [TAG_WIDTH-1:0]   w_qa_tag;
    logic                   w_a_hit;
    logic                   w_evict;

    logic                   w_sweeping;
    logic                   w_exec;
    logic                   w_snp_wr;
    logic                   w_collide;
    logic                   w_is_fill;
    logic                   w_is_inval;
    logic                   w_unused;

    // Address split for request and snoop paths
    assign w_req_idx = req_addr[LINE_BITS +: INDEX_WIDTH];
    assign w_req_tag = req_addr[TAG_LSB +: TAG_WIDTH];
    assign w_snp_idx = snp_addr[LINE_BITS +: INDEX_WIDTH];
    assign w_snp_tag = snp_addr[TAG_LSB +: TAG_WIDTH];

    // Port A read-data decode against the latched request
    assign w_qa_valid = dir_q_a[VLD_BIT];
    assign w_qa_dirty = dir_q_a[DRT_BIT];
    assign w_qa_tag   = dir_q_a[TAG_WIDTH-1:0];
    assign w_a_hit    = w_qa_valid & (w_qa_tag == r_tag);
    assign w_is_fill  = (r_op == OP_FILL);
    assign w_is_inval = (r_op == OP_INVAL);
    assign w_evict    = w_is_fill & w_qa_valid & (w_qa_tag != r_tag);

    // Phase qualifiers; reset suppresses every RAM write in the same cycle
    assign w_sweeping = ~reset & (r_state == ST_INIT);
    assign w_exec     = ~reset & (r_state == ST_EXEC);

    // Snoop invalidates only a valid entry whose tag matches
    assign w_snp_wr = ~reset & r_init_done & snp_valid & dir_q_b[VLD_BIT]
                      & (dir_q_b[TAG_WIDTH-1:0] == w_snp_tag);

    // A snoop write to the index under execution wins; the request retries next cycle
    assign w_collide = w_exec & w_snp_wr & (w_snp_idx == r_idx);

    // Port A address: even sweep index during init, latched request index otherwise
    assign dir_address_a = w_sweeping ? {r_sweep, 1'b0} : r_idx;

    // Port A write data: new valid entry on fill, zero for sweep and invalidate
    assign dir_data_a = (!w_sweeping && w_is_fill) ? {1'b1, r_dirty, r_tag} : ENTRY_W'(0);

    // Port A write enable: sweep, fill, or invalidate of a hit, unless a snoop collides
    always_comb begin
        dir_wren_a = 1'b0;
        if (w_sweeping) begin
            dir_wren_a = 1'b1;
        end else if (w_exec && !w_collide) begin
            if (w_is_fill) begin
                dir_wren_a = 1'b1;
            end else if (w_is_inval) begin
                dir_wren_a = w_a_hit;
            end
        end
    end

    // Port B: odd sweep index during init, snoop index (combinational) afterwards
    assign dir_address_b = w_sweeping ? {r_sweep, 1'b1} : w_snp_idx;
    assign dir_data_b    = ENTRY_W'(0);
    assign dir_wren_b    = w_sweeping | w_snp_wr;

    // Controller state, request latch and registered responses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= ST_INIT;
            r_sweep           <= SWEEP_W'(0);
            r_init_done       <= 1'b0;
            r_req_ready       <= 1'b0;
            r_op              <= 2'b00;
            r_idx             <= INDEX_WIDTH'(0);
            r_tag             <= TAG_WIDTH'(0);
            r_dirty           <= 1'b0;
            r_rsp_valid       <= 1'b0;
            r_rsp_hit         <= 1'b0;
            r_rsp_dirty       <= 1'b0;
            r_rsp_evict       <= 1'b0;
            r_rsp_evict_tag   <= TAG_WIDTH'(0);
            r_rsp_evict_dirty <= 1'b0;
            r_snp_hit         <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_snp_hit   <= w_snp_wr;
            case (r_state)
                ST_INIT: begin
                    r_sweep <= SWEEP_W'(r_sweep + SWEEP_W'(1));
                    if (r_sweep == {SWEEP_W{1'b1}}) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_idx       <= w_req_idx;
                        r_tag       <= w_req_tag;
                        r_dirty     <= req_dirty;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!w_collide) begin
                        r_rsp_valid       <= 1'b1;
                        r_rsp_hit         <= w_a_hit;
                        r_rsp_dirty       <= w_a_hit & w_qa_dirty;
                        r_rsp_evict       <= w_evict;
                        r_rsp_evict_tag   <= w_evict ? w_qa_tag : TAG_WIDTH'(0);
                        r_rsp_evict_dirty <= w_evict & w_qa_dirty;
                        r_req_ready       <= 1'b1;
                        r_state           <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_sweep <= SWEEP_W'(0);
                end
            endcase
        end
    end

    assign req_ready       = r_req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_hit         = r_rsp_hit;
    assign rsp_dirty       = r_rsp_dirty;
    assign rsp_evict       = r_rsp_evict;
    assign rsp_evict_tag   = r_rsp_evict_tag;
    assign rsp_evict_dirty = r_rsp_evict_dirty;
    assign snp_hit         = r_snp_hit;
    assign snp_ready       = r_init_done;
    assign init_done       = r_init_done;

    // Line-offset bits and the snooped dirty bit carry no information here
    assign w_unused = &{1'b0, req_addr[LINE_BITS-1:0], snp_addr[LINE_BITS-1:0], dir_q_b[DRT_BIT]};

endmodule

// File: tb/tb_cachedir_ctrl.sv
// tb_cachedir_ctrl: scoreboard bench for cachedir_ctrl with a behavioural directory RAM.
module tb_cachedir_ctrl;

    localparam int unsigned PA_W  = 40;
    localparam int unsigned TAG_W = 27;
    localparam int unsigned ENT_W = 29;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [PA_W-1:0]   req_addr;
    logic              req_dirty;
    logic              rsp_valid;
    logic              rsp_hit;
    logic              rsp_dirty;
    logic              rsp_evict;
    logic [TAG_W-1:0]  rsp_evict_tag;
    logic              rsp_evict_dirty;
    logic              snp_valid;
    logic              snp_ready;
    logic [PA_W-1:0]   snp_addr;
    logic              snp_hit;
    logic              init_done;
    logic              dir_wren_a;
    logic [8:0]        dir_address_a;
    logic [ENT_W-1:0]  dir_data_a;
    logic [ENT_W-1:0]  dir_q_a;
    logic              dir_wren_b;
    logic [8:0]        dir_address_b;
    logic [ENT_W-1:0]  dir_data_b;
    logic [ENT_W-1:0]  dir_q_b;

    always #5 clock = ~clock;

    cachedir_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_dirty(req_dirty),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dirty(rsp_dirty),
        .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag), .rsp_evict_dirty(rsp_evict_dirty),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_addr(snp_addr), .snp_hit(snp_hit),
        .init_done(init_done),
        .dir_wren_a(dir_wren_a), .dir_address_a(dir_address_a), .dir_data_a(dir_data_a), .dir_q_a(dir_q_a),
        .dir_wren_b(dir_wren_b), .dir_address_b(dir_address_b), .dir_data_b(dir_data_b), .dir_q_b(dir_q_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Directory RAM: asynchronous read, clocked write, garbage preload
    logic [ENT_W-1:0] mem [512];
    logic             preload;
    int               na = 0;
    int               nb = 0;

    assign dir_q_a = mem[dir_address_a];
    assign dir_q_b = mem[dir_address_b];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= ENT_W'($urandom) | ENT_W'(1);
        end else begin
            if (dir_wren_a) mem[dir_address_a] <= dir_data_a;
            if (dir_wren_b) mem[dir_address_b] <= dir_data_b;
            if (dir_wren_a && dir_wren_b)
                check("ab_same_index", 64'(dir_address_a == dir_address_b), 64'(0));
            if (init_done && dir_wren_a) na <= na + 1;
            if (init_done && dir_wren_b) nb <= nb + 1;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference directory and scoreboard
    typedef struct {
        logic             hit;
        logic             dirty;
        logic             evict;
        logic             chk_etag;
        logic [TAG_W-1:0] etag;
        logic             edirty;
        int               cyc;
    } exp_t;

    exp_t             sbq[$];
    logic [ENT_W-1:0] mdl [512];
    int               n_push = 0;
    int               n_rsp = 0;

    task automatic model_snp(input logic [PA_W-1:0] sa, output bit h);
        logic [8:0]       ix;
        logic [TAG_W-1:0] tg;
        ix = sa[12:4];
        tg = sa[39:13];
        h  = mdl[ix][28] && (mdl[ix][26:0] == tg);
        if (h) mdl[ix] = '0;
    endtask

    task automatic model_req(input logic [1:0] op, input logic [PA_W-1:0] a, input logic d, output exp_t e);
        logic [8:0]       ix;
        logic [TAG_W-1:0] tg;
        logic [ENT_W-1:0] en;
        logic             m;
        ix = a[12:4];
        tg = a[39:13];
        en = mdl[ix];
        m  = en[28] && (en[26:0] == tg);
        e.hit      = m;
        e.dirty    = m & en[27];
        e.evict    = (op == 2'b01) && en[28] && (en[26:0] != tg);
        e.etag     = e.evict ? en[26:0] : '0;
        e.edirty   = e.evict & en[27];
        e.chk_etag = (op != 2'b01) || e.evict;
        e.cyc      = 0;
        if (op == 2'b01) mdl[ix] = {1'b1, d, tg};
        else if (op == 2'b10 && m) mdl[ix] = '0;
    endtask

    // Response monitor: pop and compare on every rsp_valid pulse
    always @(negedge clock) begin
        exp_t e;
        if (rsp_valid) begin
            n_rsp++;
            check("rsp_pending", 64'(sbq.size() != 0), 64'(1));
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
                check("rsp_dirty", 64'(rsp_dirty), 64'(e.dirty));
                check("rsp_evict", 64'(rsp_evict), 64'(e.evict));
                if (e.chk_etag) begin
                    check("rsp_evict_tag", 64'(rsp_evict_tag), 64'(e.etag));
                    check("rsp_evict_dirty", 64'(rsp_evict_dirty), 64'(e.edirty));
                end
            end
        end
    end

    // Issue one request (optionally with a snoop during its EXEC cycle) and drain it
    task automatic do_req(input logic [1:0] op, input logic [PA_W-1:0] a, input logic d,
                          input bit s_en, input logic [PA_W-1:0] sa);
        exp_t e;
        bit   sh;
        bit   stall;
        int   n;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clock); n++; end
        check("req_ready", 64'(req_ready), 64'(1));
        sh = 1'b0;
        if (s_en) model_snp(sa, sh);
        stall = sh && (sa[12:4] == a[12:4]);
        model_req(op, a, d, e);
        e.cyc = cyc + 2 + (stall ? 1 : 0);
        sbq.push_back(e);
        n_push++;
        req_valid = 1'b1; req_op = op; req_addr = a; req_dirty = d;
        @(negedge clock);
        req_valid = 1'b0;
        if (s_en) begin
            snp_valid = 1'b1; snp_addr = sa;
            @(negedge clock);
            snp_valid = 1'b0;
            check("snp_hit_exec", 64'(snp_hit), 64'(sh));
        end
        n = 0;
        while (sbq.size() != 0 && n < 20) begin @(negedge clock); n++; end
        check("rsp_drain", 64'(sbq.size()), 64'(0));
    endtask

    // Standalone snoop while idle
    task automatic do_snoop(input logic [PA_W-1:0] sa);
        bit sh;
        int b0;
        model_snp(sa, sh);
        b0 = nb;
        snp_valid = 1'b1; snp_addr = sa;
        @(negedge clock);
        snp_valid = 1'b0;
        check("snp_hit", 64'(snp_hit), 64'(sh));
        check("snp_bwrites", 64'(nb - b0), 64'(sh));
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 1000) begin @(negedge clock); n++; end
    endtask

    localparam logic [PA_W-1:0] A_MAIN = 40'h00_1234_5670;
    localparam logic [PA_W-1:0] A_EV1  = 40'h00_0000_2010;
    localparam logic [PA_W-1:0] A_EV2  = 40'h00_0000_4010;
    localparam logic [PA_W-1:0] A_X    = 40'h00_0ABC_D000;
    localparam logic [PA_W-1:0] A_NONE = 40'h00_5555_5550;
    localparam logic [PA_W-1:0] A_RST  = 40'h00_0007_E070;

    initial begin
        int        n;
        int        nz;
        int        na0;
        bit        early;
        logic [PA_W-1:0] ra;
        logic [PA_W-1:0] sa;
        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_dirty = 1'b0;
        snp_valid = 1'b0; snp_addr = '0;
        foreach (mdl[i]) mdl[i] = '0;
        @(negedge clock);
        preload = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_snp_ready", 64'(snp_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_snp_hit", 64'(snp_hit), 64'(0));
        check("rst_wren_a", 64'(dir_wren_a), 64'(0));
        check("rst_wren_b", 64'(dir_wren_b), 64'(0));

        // Sweep timing and result
        reset = 1'b0;
        n = 0; early = 1'b0;
        while (!init_done && n < 1000) begin
            @(negedge clock); n++;
            if (!init_done) early = early | req_ready | snp_ready;
        end
        check("init_cycles", 64'(n), 64'(256));
        check("early_ready", 64'(early), 64'(0));
        check("snp_ready", 64'(snp_ready), 64'(1));
        nz = 0;
        foreach (mem[i]) if (mem[i] != '0) nz++;
        check("sweep_nonzero", 64'(nz), 64'(0));

        // Fill then lookup
        do_req(2'b01, A_MAIN, 1'b1, 1'b0, '0);
        do_req(2'b00, A_MAIN, 1'b0, 1'b0, '0);

        // Eviction at index 1
        do_req(2'b01, A_EV1, 1'b1, 1'b0, '0);
        do_req(2'b01, A_EV2, 1'b0, 1'b0, '0);
        do_req(2'b00, A_EV1, 1'b0, 1'b0, '0);

        // Snoop invalidate and snoop miss
        do_req(2'b01, A_X, 1'b0, 1'b0, '0);
        do_snoop(A_X);
        do_req(2'b00, A_X, 1'b0, 1'b0, '0);
        do_snoop(A_NONE);

        // Invalidate colliding with a snoop of the same line
        do_req(2'b01, A_X, 1'b1, 1'b0, '0);
        na0 = na;
        do_req(2'b10, A_X, 1'b0, 1'b1, A_X);
        check("collide_awrites", 64'(na - na0), 64'(0));

        // Mixed traffic over a small aliasing address pool
        for (int i = 0; i < 40; i++) begin
            ra = {27'(5 + $urandom_range(0, 1)), 9'($urandom_range(1, 3)), 4'($urandom_range(0, 15))};
            sa = {27'(5 + $urandom_range(0, 1)), 9'($urandom_range(1, 3)), 4'h0};
            do_req(2'($urandom_range(0, 3)), ra, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), sa);
            if ($urandom_range(0, 4) == 0) do_snoop(sa);
        end

        // Reset during EXEC of a fill
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clock); n++; end
        req_valid = 1'b1; req_op = 2'b01; req_addr = A_RST; req_dirty = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("rst_exec_rsp", 64'(rsp_valid), 64'(0));
        check("rst_exec_init", 64'(init_done), 64'(0));
        reset = 1'b0;
        #1;
        check("restart_addr_a", 64'(dir_address_a), 64'(0));
        check("restart_wren_a", 64'(dir_wren_a), 64'(1));
        check("restart_addr_b", 64'(dir_address_b), 64'(1));
        foreach (mdl[i]) mdl[i] = '0;
        @(negedge clock);
        wait_init(n);
        check("reinit_cycles", 64'(n), 64'(255));
        check("rst_entry", 64'(mem[9'h007]), 64'(0));
        do_req(2'b00, A_RST, 1'b0, 1'b0, '0);

        repeat (3) @(negedge clock);
        check("rsp_count", 64'(n_rsp), 64'(n_push));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cachedir_ctrl.md
Name: cachedir_ctrl

Overview:
- Directory controller that sits directly in front of the 512×29 dual-port cache directory RAM. The RAM reads asynchronously and writes on the clock edge.
- Serves lookup, fill and invalidate requests from the bridge on RAM port A.
- Serves single-cycle coherence snoop invalidations on port B.
- After reset, sweeps the whole RAM clear before accepting any traffic.

Parameters:
- PA_WIDTH, 40: physical address width.
- LINE_BITS, 4: log2 of the line size in bytes; address bits [3:0] are ignored.
- INDEX_WIDTH, 9: directory index width (512 entries).
- TAG_WIDTH, 27: derived as PA_WIDTH-LINE_BITS-INDEX_WIDTH. Entry width is TAG_WIDTH+2 and must equal 29.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&req_ready
- req_op  in  2  00 lookup, 01 fill, 10 invalidate, 11 reserved (treated as lookup)
- req_addr  in  PA_WIDTH  request physical address
- req_dirty  in  1  dirty bit written on fill
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_hit  out  1  entry valid and tag match, evaluated before any update
- rsp_dirty  out  1  dirty bit of the matching entry
- rsp_evict  out  1  fill displaced a valid entry with a different tag
- rsp_evict_tag  out  TAG_WIDTH  tag of the displaced entry
- rsp_evict_dirty  out  1  dirty bit of the displaced entry
- snp_valid  in  1  snoop invalidate request
- snp_ready  out  1  equals init_done
- snp_addr  in  PA_WIDTH  snoop physical address
- snp_hit  out  1  registered; high the cycle after a snoop that invalidated an entry
- init_done  out  1  directory sweep complete
- dir_wren_a, dir_address_a[8:0], dir_data_a[28:0], dir_q_a[28:0]  out/out/out/in  RAM port A
- dir_wren_b, dir_address_b[8:0], dir_data_b[28:0], dir_q_b[28:0]  out/out/out/in  RAM port B

Behaviour:
- Entry format: [28] valid, [27] dirty, [26:0] tag.
- Address split: index = addr[12:4], tag = addr[39:13].
- Reset values: state INIT, sweep counter 0. The following are all 0: init_done, req_ready, snp_ready, rsp_*, snp_hit, dir_wren_*.
- States:
  - INIT: each cycle port A writes 0 to index 2k and port B writes 0 to index 2k+1, for k=0..255 (256 cycles). After the k=255 write, go to IDLE and set init_done, which stays high until reset.
  - IDLE: req_ready=1. On handshake, latch op/addr/dirty and go to EXEC.
  - EXEC: dir_address_a = latched index; compare dir_q_a against the latched tag.
    - lookup: no write.
    - fill: write {1, req_dirty, tag}. rsp_evict = q.valid & tag mismatch, and evict_tag/evict_dirty are taken from q.
    - invalidate: write 0 only if hit.
    - Responses are registered; next state is IDLE.
- Latency: request accepted in cycle N, EXEC in N+1, rsp_valid in N+2. The next request can be accepted in N+2, giving throughput of one request per 2 cycles.
- rsp_* fields other than rsp_valid hold their last value when rsp_valid=0. rsp_evict and evict fields are 0 for non-fill ops.
- Snoop, when init_done:
  - dir_address_b = snp index, combinationally.
  - dir_wren_b = snp_valid & dir_q_b.valid & tag match, with dir_data_b = 0.
  - snp_hit is registered from dir_wren_b.
  - Snoops are never stalled.
- Collision rule: if in EXEC a snoop hits the same index as the latched request, the request stays in EXEC with no port-A write and no response. Next cycle it re-evaluates against the updated dir_q_a. The stall is bounded because a repeated snoop of the same line misses.
- A snoop hitting a different index than EXEC proceeds in parallel with the port-A write.
- Reset asserted mid-operation: any in-flight request is dropped with no response, and the sweep restarts at k=0.
- The controller never drives port A and port B to the same index with both write enables high.

Test Plan:
- Reset, hold 256 cycles: init_done rises exactly at cycle 256; all 512 entries read 0; req_ready and snp_ready are 0 before init_done.
- Fill 0x00_1234_5670 with dirty=1, then lookup the same address: fill rsp_hit=0, rsp_evict=0; lookup rsp_hit=1, rsp_dirty=1, with rsp_valid 2 cycles after each accept.
- Fill 0x00_0000_2010, then fill 0x00_0000_4010 (same index 0x001, different tag): second response rsp_evict=1, evict_tag=0x1, evict_dirty matches the first fill.
- Fill line X, then snoop X: snp_hit=1 next cycle; a following lookup of X gives rsp_hit=0. Snooping an unfilled line gives snp_hit=0 with no RAM write.
- Fill line X, then issue an invalidate for X with a snoop of X in the same EXEC cycle: one stall cycle, then response rsp_hit=0 with no port-A write; port A and port B never both write the same index.
- Assert reset during EXEC of a fill: no rsp_valid, the sweep restarts at index 0, and the entry reads 0 after init_done.
